// File: rtl/alu_nibble_sequencer.sv
// Sequences WIDTH-bit ALU operations through an external 4-bit CLA slice,
// one nibble per cycle (LSB first), and assembles the result and flags.
module alu_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_op,
    output logic [3:0]       slice_a,
    output logic [3:0]       slice_b,
    output logic             slice_c_in,
    output logic [2:0]       slice_op,
    input  logic [3:0]       slice_result,
    input  logic             slice_p,
    input  logic             slice_g,
    input  logic             slice_c_last,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_overflow,
    output logic             rsp_zero
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = $clog2(NIB);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q, b_q, result_q, result_d;
    logic [2:0]         op_q;
    logic [IW-1:0]      idx_q;
    logic               carry_q;
    logic               rsp_carry_q, rsp_ovf_q, rsp_zero_q;

    logic [3:0]         a_nib [NIB];
    logic [3:0]         b_nib [NIB];
    logic               op_known, op_arith, op_slt, last_nib, carry_out, ovf_d;

    for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
        assign a_nib[gi] = a_q[gi*4 +: 4];
        assign b_nib[gi] = b_q[gi*4 +: 4];
    end

    assign op_known  = (op_q == 3'b000) || (op_q == 3'b001) || (op_q == 3'b010) ||
                       (op_q == 3'b110) || (op_q == 3'b111);
    assign op_arith  = (op_q == 3'b010) || (op_q == 3'b110) || (op_q == 3'b111);
    assign op_slt    = (op_q == 3'b111);
    assign last_nib  = (idx_q == IW'(NIB - 1));

    assign slice_a    = a_nib[idx_q];
    assign slice_b    = b_nib[idx_q];
    assign slice_c_in = carry_q;
    assign slice_op   = op_known ? op_q : 3'b000;

    assign carry_out  = slice_g | (slice_p & slice_c_in);
    assign ovf_d      = op_arith & (slice_c_last ^ carry_out);

    // Reserved ops leave the result at the zero loaded on accept.
    always_comb begin
        result_d = result_q;
        if (op_known) begin
            for (int i = 0; i < NIB; i++) begin
                if (idx_q == IW'(i)) result_d[i*4 +: 4] = slice_result;
            end
            if (op_slt && last_nib) begin
                result_d = '0;
                result_d[0] = slice_result[3] ^ ovf_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 3'b000;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            rsp_carry_q <= 1'b0;
            rsp_ovf_q   <= 1'b0;
            rsp_zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        state_q     <= RUN;
                        a_q         <= req_a;
                        b_q         <= req_b;
                        op_q        <= req_op;
                        idx_q       <= '0;
                        carry_q     <= req_op[2];
                        result_q    <= '0;
                        rsp_carry_q <= 1'b0;
                        rsp_ovf_q   <= 1'b0;
                        rsp_zero_q  <= 1'b0;
                    end
                end
                RUN: begin
                    result_q <= result_d;
                    carry_q  <= carry_out;
                    idx_q    <= idx_q + 1'b1;
                    if (last_nib) begin
                        state_q     <= DONE;
                        idx_q       <= '0;
                        rsp_carry_q <= op_arith & carry_out;
                        rsp_ovf_q   <= ovf_d;
                        rsp_zero_q  <= (result_d == '0);
                    end
                end
                DONE: begin
                    if (rsp_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign rsp_valid    = (state_q == DONE);
    assign rsp_result   = result_q;
    assign rsp_carry    = rsp_carry_q;
    assign rsp_overflow = rsp_ovf_q;
    assign rsp_zero     = rsp_zero_q;
endmodule
